// File: rtl/router_pkg.sv
// Shared types and constants for the router egress packet receiver.
// Header layout, parser state encoding and output-buffer entry format.
package router_pkg;
  localparam int BYTE_W   = 8;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2,
    DONE    = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [BYTE_W-1:0] data;
  } obuf_ent_t;
endpackage

// File: rtl/rx_obuf.sv
// Circular holding buffer of {sop, eop, data} entries.
// Ports: i_push/i_ent write, i_pop/o_ent read head, o_count/o_empty status.
module rx_obuf
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  obuf_ent_t        i_ent,
  input  logic             i_pop,
  output obuf_ent_t        o_ent,
  output logic [AW:0]      o_count,
  output logic             o_empty
);
  obuf_ent_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // a push into a full buffer is legal only alongside a pop
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_ent   = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_ent;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push}
                     - {{AW{1'b0}}, w_pop};
    end
  end
endmodule

// File: rtl/router_pkt_rx.sv
// Router egress consumer: drains a port FIFO, parses and parity-checks
// packets, re-emits bytes as a valid/ready stream with sop/eop tags.
// Ports: clock, reset, vld_out, data_out, read_enb, m_valid, m_ready,
// m_data, m_sop, m_eop, pkt_done, parity_err, addr_err, trunc_err, busy.
// Macro ROUTER_PKT_RX_STATS_EN adds pkt_count/err_count outputs.
module router_pkt_rx
  import router_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int STALL_MAX = 64,
  parameter int PORT_ID   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vld_out,
  input  logic [BYTE_W-1:0] data_out,
  output logic              read_enb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              addr_err,
  output logic              trunc_err,
`ifdef ROUTER_PKT_RX_STATS_EN
  output logic [15:0]       pkt_count,
  output logic [15:0]       err_count,
`endif
  output logic              busy
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int SW = $clog2(STALL_MAX + 1);

  rx_state_t          r_state;
  rx_state_t          w_next;
  logic               r_ena;
  logic               r_inflight;
  logic [LEN_W-1:0]   r_rem;
  logic [BYTE_W-1:0]  r_par;
  logic [SW-1:0]      r_stall;
  logic               r_pkt_done;
  logic               r_perr;
  logic               r_aerr;
  logic               r_terr;

  logic               w_cap;
  logic               w_hdr;
  logic               w_tail;
  logic               w_stalling;
  logic               w_abort;
  logic               w_room;
  logic               w_empty;
  logic [AW:0]        w_cnt;
  obuf_ent_t          w_in;
  obuf_ent_t          w_head;
  logic [LEN_W-1:0]   w_len;
  logic [ADDR_W-1:0]  w_addr;

  assign w_cap  = r_inflight;
  assign w_len  = data_out[LEN_MSB:LEN_LSB];
  assign w_addr = data_out[ADDR_MSB:ADDR_LSB];
  // a byte landing in DONE was read in the parity cycle: it is a header
  assign w_hdr  = w_cap &
                  (r_state == IDLE | r_state == DONE);
  assign w_tail = w_cap & (r_state == PARITY);

  assign w_stalling = (r_state == PAYLOAD | r_state == PARITY)
                      & ~w_cap;
  assign w_abort    = w_stalling &
                      (r_stall == SW'(STALL_MAX - 1));

  // count + in-flight < depth, i.e. a free slot is still unreserved
  assign w_room = ({1'b0, w_cnt} + {{(AW+1){1'b0}}, r_inflight})
                  < (AW+2)'(BUF_DEPTH);

  assign read_enb = r_ena & vld_out & (r_state != DONE) & w_room;

  assign w_in.sop  = w_hdr;
  assign w_in.eop  = w_tail;
  assign w_in.data = data_out;

  rx_obuf #(.DEPTH(BUF_DEPTH)) u_obuf (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_cap),
    .i_ent   (w_in),
    .i_pop   (m_ready),
    .o_ent   (w_head),
    .o_count (w_cnt),
    .o_empty (w_empty)
  );

  assign m_valid    = ~w_empty;
  assign m_data     = w_head.data & {BYTE_W{m_valid}};
  assign m_sop      = w_head.sop & m_valid;
  assign m_eop      = w_head.eop & m_valid;
  assign pkt_done   = r_pkt_done;
  assign parity_err = r_perr;
  assign addr_err   = r_aerr;
  assign trunc_err  = r_terr;
  assign busy       = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (r_state == DONE) w_next = IDLE;
        if (w_cap)
          w_next = (w_len == '0) ? PARITY : PAYLOAD;
      end
      PAYLOAD: begin
        if (w_abort) w_next = IDLE;
        else if (w_cap && r_rem == LEN_W'(1))
          w_next = PARITY;
      end
      PARITY: begin
        if (w_abort)    w_next = IDLE;
        else if (w_cap) w_next = DONE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ena      <= 1'b0;
      r_inflight <= 1'b0;
      r_rem      <= '0;
      r_par      <= '0;
      r_stall    <= '0;
      r_pkt_done <= 1'b0;
      r_perr     <= 1'b0;
      r_aerr     <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ena      <= 1'b1;
      // a read issued as the packet aborts is dropped on arrival
      r_inflight <= read_enb & ~w_abort;
      if (w_stalling && !w_abort) r_stall <= r_stall + 1'b1;
      else                        r_stall <= '0;
      if (w_hdr) begin
        r_rem <= w_len;
        r_par <= data_out;
      end else if (w_cap && r_state == PAYLOAD) begin
        r_rem <= r_rem - LEN_W'(1);
        r_par <= r_par ^ data_out;
      end
      r_pkt_done <= w_tail;
      r_perr     <= w_tail & (data_out != r_par);
      r_aerr     <= w_hdr & (w_addr != ADDR_W'(PORT_ID));
      r_terr     <= w_abort;
    end
  end

`ifdef ROUTER_PKT_RX_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;
  logic        w_any_err;

  assign w_any_err = r_perr | r_aerr | r_terr;
  assign pkt_count = r_pkt_cnt;
  assign err_count = r_err_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (r_pkt_done && r_pkt_cnt != 16'hFFFF)
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_any_err && r_err_cnt != 16'hFFFF)
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_router_pkt_rx.sv
// Bench for router_pkt_rx: router FIFO model, packet-level stream model,
// per-cycle stream compare and directed scenario checks.
module tb_router_pkt_rx;
  logic       clock = 1'b0;
  logic       reset;
  logic       vld_out;
  logic [7:0] data_out;
  logic       read_enb;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_sop;
  logic       m_eop;
  logic       pkt_done;
  logic       parity_err;
  logic       addr_err;
  logic       trunc_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rf[$];
  logic [9:0]  exp_q[$];
  int rd_cnt = 0;
  int n_done = 0, n_perr = 0, n_aerr = 0, n_terr = 0;
  int e_done = 0, e_perr = 0, e_aerr = 0, e_terr = 0;
  logic [7:0] last_par;

  router_pkt_rx dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .trunc_err  (trunc_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // router port FIFO: read data appears the cycle after read_enb
  always @(posedge clock) begin
    if (read_enb && rf.size() > 0) begin
      data_out <= rf.pop_front();
      rd_cnt++;
    end
    vld_out <= (rf.size() != 0);
  end

  // stream and pulse compare against the packet model
  always @(negedge clock) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0)
          check("stream_extra", {22'd0, m_sop, m_eop, m_data}, 32'h3ff);
        else
          check("stream", {22'd0, m_sop, m_eop, m_data},
                {22'd0, exp_q.pop_front()});
      end
      if (parity_err && !pkt_done)
        check("perr_without_done", 0, 1);
      if (pkt_done)   n_done++;
      if (parity_err) n_perr++;
      if (addr_err)   n_aerr++;
      if (trunc_err)  n_terr++;
    end
  end

  // packet model: header, npay bytes of k*base, then parity if complete
  task automatic push_pkt(input logic [7:0] hdr, input int npay,
                          input logic [7:0] base, input bit bad_par,
                          input bit complete);
    logic [7:0] p, b;
    p = hdr;
    rf.push_back(hdr);
    exp_q.push_back({1'b1, 1'b0, hdr});
    for (int i = 0; i < npay; i++) begin
      b = 8'(base * (i + 1));
      p ^= b;
      rf.push_back(b);
      exp_q.push_back({2'b00, b});
    end
    if (bad_par) p ^= 8'h01;
    last_par = p;
    if (complete) begin
      rf.push_back(p);
      exp_q.push_back({2'b01, p});
      e_done++;
      if (bad_par) e_perr++;
    end else begin
      e_terr++;
    end
    if (hdr[1:0] != 2'd0) e_aerr++;
    vld_out = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (k < 400 && (exp_q.size() != 0 || rf.size() != 0 || busy)) begin
      @(negedge clock);
      k++;
    end
    if (k >= 400) check({nm, "_timeout"}, 0, 1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset   = 1'b1;
    m_ready = 1'b1;
    vld_out = 1'b0;
    data_out = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_mvalid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rden", read_enb, 0);
    check("rst_pulses", {pkt_done, parity_err, addr_err, trunc_err}, 0);
    reset = 1'b0;
    @(negedge clock);

    push_pkt(8'h0C, 3, 8'h11, 0, 1);
    check("t1_model_par", last_par, 8'h0C);
    wait_idle("t1");
    check("t1_done", n_done, 1);
    check("t1_perr", n_perr, 0);

    push_pkt(8'h0C, 3, 8'h11, 1, 1);
    check("t2_model_par", last_par, 8'h0D);
    wait_idle("t2");
    check("t2_done", n_done, 2);
    check("t2_perr", n_perr, 1);

    push_pkt(8'h00, 0, 8'h11, 0, 1);
    wait_idle("t3");
    check("t3_done", n_done, 3);
    check("t3_perr", n_perr, 1);

    push_pkt(8'h09, 2, 8'h11, 0, 1);
    wait_idle("t4");
    check("t4_aerr", n_aerr, 1);
    check("t4_done", n_done, 4);

    m_ready = 1'b0;
    rd_cnt  = 0;
    push_pkt(8'h20, 8, 8'h11, 0, 1);
    repeat (20) @(negedge clock);
    check("bp_reads", rd_cnt, 4);
    check("bp_rden", read_enb, 0);
    check("bp_mvalid", m_valid, 1);
    m_ready = 1'b1;
    wait_idle("bp");
    check("bp_reads_all", rd_cnt, 10);
    check("bp_done", n_done, 5);

    push_pkt(8'h14, 2, 8'h11, 0, 0);
    begin
      int k;
      k = 0;
      while (k < 300 && n_terr == 0) begin
        @(negedge clock);
        k++;
      end
      if (k >= 300) check("trunc_timeout", 0, 1);
    end
    check("trunc_busy", busy, 0);
    wait_idle("trunc");
    check("trunc_cnt", n_terr, 1);
    check("trunc_done", n_done, 5);

    push_pkt(8'h0C, 3, 8'h11, 0, 1);
    wait_idle("post_trunc");
    check("post_trunc_done", n_done, 6);

    m_ready = 1'b0;
    push_pkt(8'h20, 8, 8'h11, 0, 1);
    e_done--;
    repeat (6) @(negedge clock);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_mvalid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_rden", read_enb, 0);
    rf.delete();
    exp_q.delete();
    vld_out = 1'b0;
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    m_ready = 1'b1;
    @(negedge clock);
    push_pkt(8'h0C, 3, 8'h11, 0, 1);
    wait_idle("post_rst");
    check("post_rst_done", n_done, 7);

    check("end_stream_left", exp_q.size(), 0);
    check("end_done", n_done, e_done);
    check("end_perr", n_perr, e_perr);
    check("end_aerr", n_aerr, e_aerr);
    check("end_terr", n_terr, e_terr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_pkt_rx.md
Name: router_pkt_rx

Overview:
- Egress consumer for one router output port; one instance per port, sitting directly downstream of the router's data_out_N/vld_out_N/read_enb_N.
- Drains the port FIFO and parses each packet: a header byte (length in [7:2], address in [1:0]), then `length` payload bytes, then one parity byte.
- Checks parity and re-emits the bytes as a valid/ready byte stream with sop/eop markers.
- Reads promptly enough that the router's 30-cycle idle soft-reset does not fire while the consumer has space.

Parameters:
- BUF_DEPTH, 4, output holding-buffer entries (power of 2, ≥2).
- STALL_MAX, 64, max cycles with no byte arriving mid-packet before the packet is aborted.
- PORT_ID, 0, expected address field; a mismatch sets addr_err.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- vld_out  in  1  router port FIFO non-empty.
- data_out  in  8  router FIFO read data; valid one cycle after read_enb.
- read_enb  out  1  FIFO read strobe.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accept.
- m_data  out  8  output byte.
- m_sop  out  1  m_data is a header byte.
- m_eop  out  1  m_data is a parity byte.
- pkt_done  out  1  1-cycle pulse when the parity byte is received.
- parity_err  out  1  1-cycle pulse with pkt_done when the XOR check fails.
- addr_err  out  1  1-cycle pulse when a header address ≠ PORT_ID.
- trunc_err  out  1  1-cycle pulse on stall abort.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - Buffer empty.
  - State IDLE.
  - Counters and running parity cleared.
- Read latency is 1:
  - A byte is captured at edge N+1 when read_enb is high in cycle N.
  - An in-flight flag marks the outstanding read.
- Read rule: read_enb = vld_out & (state ≠ DONE) & (free entries − in_flight ≥ 1). There is never more than one read in flight, so the buffer cannot overflow.
- States:
  - IDLE: wait for a captured byte, which is the header.
    - Load rem = hdr[7:2] and parity = hdr.
    - Tag the entry sop.
    - If hdr[1:0] ≠ PORT_ID, pulse addr_err; the packet is still forwarded.
    - Go to PAYLOAD, or PARITY if rem = 0.
  - PAYLOAD: on each captured byte, parity ^= byte and rem−1. At rem = 1 → PARITY.
  - PARITY: the captured byte is tagged eop.
    - Pulse pkt_done.
    - Pulse parity_err if byte ≠ parity.
    - → DONE.
  - DONE: one cycle; no read issued; → IDLE. This guarantees that the next header is never merged into the current packet.
- Stall timer:
  - Counts cycles in PAYLOAD/PARITY with no byte captured; it resets on every capture.
  - On reaching STALL_MAX: pulse trunc_err and go to IDLE.
  - Buffered bytes are still emitted; the last emitted byte of the truncated packet is not tagged eop.
  - A read in flight at abort is discarded.
- Output buffer: circular FIFO of {sop, eop, data}.
  - m_valid = non-empty; pop on m_valid & m_ready.
  - Push and pop in the same cycle are allowed while full.
- Backpressure: with m_ready held low, read_enb deasserts once the buffer is full; the router FIFO absorbs the rest.
- vld_out dropping mid-packet is normal; reading resumes when it returns.
- Reset mid-packet: everything clears immediately and asynchronously. Partial packet contents are lost.

Optional Feature:
- Macro ROUTER_PKT_RX_STATS_EN.
- Defined: adds outputs pkt_count[15:0] and err_count[15:0].
  - pkt_count increments on pkt_done.
  - err_count increments on any of parity_err, addr_err or trunc_err (at most +1 per cycle).
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package router_pkg:
  - Header field positions: LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0.
  - State enum rx_state_t {IDLE, PAYLOAD, PARITY, DONE} (2 bits).
  - Byte width constant 8.
- Sub-module rx_obuf holds the {sop, eop, data} circular buffer, exposing push/pop/count.
- Parser FSM and stall timer stay in router_pkt_rx.

Test Plan:
- Header 8'h0C (len 3, addr 0), payload 11,22,33, parity 0C^11^22^33=8'h0C, m_ready=1.
  - Expect 5 bytes out: sop on 0C, eop on the parity byte.
  - Expect pkt_done pulse and no parity_err.
- Same packet with parity byte 8'h0D → pkt_done and parity_err in the same cycle.
- Header 8'h00 (len 0), parity 8'h00 → immediate PARITY, 2 bytes out, pkt_done.
- Hold m_ready=0 with a 10-byte packet available → read_enb stops after 4 captures, m_valid high. Release m_ready → all 10 bytes arrive in order, none lost.
- Header with len 5 and only 2 payload bytes, then vld_out=0 for 64 cycles → trunc_err pulse, busy=0, no eop emitted.
- Assert reset mid-PAYLOAD → m_valid, busy and read_enb drop to 0 the same cycle. The next clean packet after reset parses correctly.
